tape_in_conditioner: RTL and testbench
======================================

TAPE_IN_CONDITIONER -- requirements
Module: tape_in_conditioner

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: consecutive equal samples (range 2..16) required to accept a level change.
REQ-002 SHALL have parameter HOLDOFF, default 64: ce ticks after an accepted change during which further changes are ignored.
REQ-003 SHALL have parameter ACT_TIMEOUT, default 2_000_000: ce ticks without an edge before activity_o drops.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ce, input, 1: sample strobe, one clk wide; nominally 21.3 MHz.
REQ-007 SHALL have port tape_raw, input, 1: asynchronous line-in comparator or UART_RX level.
REQ-008 SHALL have port invert, input, 1: when 1, tape_raw is inverted before synchronisation.
REQ-009 SHALL have port tape_o, output, 1: conditioned level feeding the console tape input.
REQ-010 SHALL have port edge_o, output, 1: one-clk pulse on every accepted rising edge of tape_o.
REQ-011 SHALL have port period_o, output, 16: ce ticks between the last two accepted rising edges.
REQ-012 SHALL have port period_valid_o, output, 1: one-clk pulse when period_o updates.
REQ-013 SHALL have port activity_o, output, 1: tape signal present (LED drive).

Function
REQ-014 SHALL synchronise (tape_raw XOR invert) through 2 flops on every clk, regardless of ce.
REQ-015 SHALL shift the synchronised bit into a FILT_LEN-bit window only on cycles with ce=1.
REQ-016 SHALL implement FSM states LOW, HIGH, HOLD_LOW and HOLD_HIGH; tape_o is 1 in HIGH and HOLD_HIGH.
REQ-017 SHALL transition LOW->HOLD_HIGH when the window is all ones, and HIGH->HOLD_LOW when it is all zeros, both evaluated on a ce cycle.
REQ-018 SHALL load the hold-off counter with HOLDOFF-1 on entry to a HOLD state and decrement it per ce.
REQ-019 SHALL leave HOLD_x for x at the ce where the counter is 0.
REQ-020 SHALL ignore window content while in a HOLD state.
REQ-021 SHALL update tape_o in the same clk as the FSM transition; input-to-output latency is 2 clk plus FILT_LEN ce ticks.
REQ-022 SHALL assert edge_o for exactly one clk on each LOW->HOLD_HIGH transition.
REQ-023 SHALL run a 16-bit period counter that increments per ce and saturates at 16'hFFFF without wrapping.
REQ-024 SHALL, on edge_o, capture the counter into period_o (value 16'hFFFF if saturated) and clear the counter to 0 in the same clk.
REQ-025 SHALL pulse period_valid_o together with edge_o, except on the first rising edge after reset, which only arms the counter.
REQ-026 SHALL record no rising edge when an input change is shorter than FILT_LEN ce ticks.
REQ-027 SHALL give reset priority over ce and over any transition occurring in the same clk.
REQ-028 SHALL treat a toggle of invert mid-stream as an ordinary input change, filtered and subject to hold-off.

Reset
REQ-029 SHALL on reset set the FSM to LOW, clear the synchronisers, window, hold-off counter and period counter, and clear the armed flag.
REQ-030 SHALL drive tape_o=0, edge_o=0, period_o=0, period_valid_o=0 and activity_o=0 during reset and in the first cycle after it.

Configuration
REQ-031 SHALL support macro TAPE_ACTIVITY_LED_EN: when defined, a 24-bit down counter reloads to ACT_TIMEOUT on each edge_o and decrements per ce to 0; activity_o=1 while the counter is non-zero.
REQ-032 SHALL, when TAPE_ACTIVITY_LED_EN is undefined, tie activity_o to 0 and synthesise no activity counter.

Structure
REQ-033 SHALL define the FSM state enum, PERIOD_W=16 and ACT_W=24 in shared package tape_in_pkg.
REQ-034 SHALL place the 2-flop synchroniser in sub-module tape_in_sync, with ports clk, reset, d and q.

Verification (FILT_LEN=4, HOLDOFF=8, ACT_TIMEOUT=100, ce every 2nd clk)
REQ-035 SHALL check: tape_raw 0->1 held -> tape_o rises 2 clk + 4 ce after the change; edge_o pulses once; period_valid_o stays 0 (first edge).
REQ-036 SHALL check: square wave with period 40 ce, after the first edge -> every following rising edge gives period_valid_o with period_o=40.
REQ-037 SHALL check: a 3-ce high glitch on a low line -> tape_o stays 0 and edge_o never pulses; a 2-ce low dip inside hold-off -> tape_o stays 1.
REQ-038 SHALL check: 70000 ce with no edge, then one rising edge -> period_o=16'hFFFF.
REQ-039 SHALL check: with TAPE_ACTIVITY_LED_EN, one edge -> activity_o=1 for exactly 100 ce then 0; without the macro -> activity_o stays 0.
REQ-040 SHALL check: reset asserted mid-HOLD_HIGH with ce=1 in the same clk -> next cycle all outputs 0, FSM in LOW, next edge does not pulse period_valid_o.

Source files
------------

// File: rtl/tape_in_pkg.sv
// Shared types and widths for the tape input conditioner.
package tape_in_pkg;

    localparam int PERIOD_W = 16;
    localparam int ACT_W    = 24;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_HIGH      = 2'd1,
        ST_HOLD_LOW  = 2'd2,
        ST_HOLD_HIGH = 2'd3
    } tape_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        if (v == {PERIOD_W{1'b1}}) begin
            return v;
        end else begin
            return v + PERIOD_W'(1'b1);
        end
    endfunction

endpackage

// File: rtl/tape_in_sync.sv
// Two-flop synchroniser for the asynchronous tape level.
module tape_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Metastability chain, clocked every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tape_in_conditioner.sv
// Tape input conditioner: sync, glitch filter, hold-off FSM and edge period timer.
// Optional activity LED counter is built only when TAPE_ACTIVITY_LED_EN is defined.
module tape_in_conditioner
    import tape_in_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int HOLDOFF     = 64,
    parameter int ACT_TIMEOUT = 2_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                tape_raw,
    input  logic                invert,
    output logic                tape_o,
    output logic                edge_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_valid_o,
    output logic                activity_o
);

    localparam int                HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF - 1);

    logic                sync_s;
    logic                rise_s;
    logic [FILT_LEN-1:0] win_q;
    logic [FILT_LEN-1:0] win_d;
    tape_state_e         state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                tape_q;
    logic                edge_q;
    logic                pvalid_q;
    logic                armed_q;
    logic [PERIOD_W-1:0] pcnt_q;
    logic [PERIOD_W-1:0] period_q;

    tape_in_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tape_raw ^ invert),
        .q     (sync_s)
    );

    // Sample window advances only on strobe cycles.
    always_comb begin
        win_d = win_q;
        if (ce) begin
            win_d = {win_q[FILT_LEN-2:0], sync_s};
        end else begin
            win_d = win_q;
        end
    end

    // The FSM judges the window including this strobe's sample.
    assign rise_s = ce && (state_q == ST_LOW) && (&win_d);

    // Window register.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    // Level FSM with hold-off, edge pulse and period capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOW;
            hold_q   <= '0;
            tape_q   <= 1'b0;
            edge_q   <= 1'b0;
            pvalid_q <= 1'b0;
            armed_q  <= 1'b0;
            pcnt_q   <= '0;
            period_q <= '0;
        end else begin
            edge_q   <= 1'b0;
            pvalid_q <= 1'b0;
            if (ce) begin
                pcnt_q <= sat_inc(pcnt_q);
                case (state_q)
                    ST_LOW: begin
                        if (rise_s) begin
                            state_q <= ST_HOLD_HIGH;
                            hold_q  <= HOLD_INIT;
                            tape_q  <= 1'b1;
                            edge_q  <= 1'b1;
                            armed_q <= 1'b1;
                            pcnt_q  <= '0;
                            // The first edge after reset only starts the timer.
                            if (armed_q) begin
                                period_q <= sat_inc(pcnt_q);
                                pvalid_q <= 1'b1;
                            end else begin
                                period_q <= period_q;
                            end
                        end else begin
                            state_q <= ST_LOW;
                        end
                    end
                    ST_HIGH: begin
                        if (~|win_d) begin
                            state_q <= ST_HOLD_LOW;
                            hold_q  <= HOLD_INIT;
                            tape_q  <= 1'b0;
                        end else begin
                            state_q <= ST_HIGH;
                        end
                    end
                    ST_HOLD_HIGH: begin
                        if (hold_q == '0) begin
                            state_q <= ST_HIGH;
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1'b1);
                        end
                    end
                    ST_HOLD_LOW: begin
                        if (hold_q == '0) begin
                            state_q <= ST_LOW;
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1'b1);
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        tape_q  <= 1'b0;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign tape_o         = tape_q;
    assign edge_o         = edge_q;
    assign period_o       = period_q;
    assign period_valid_o = pvalid_q;

`ifdef TAPE_ACTIVITY_LED_EN
    logic [ACT_W-1:0] act_q;
    logic             act_led_q;

    // Retriggerable activity timer; the LED flag mirrors a non-zero count.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q     <= '0;
            act_led_q <= 1'b0;
        end else if (rise_s) begin
            act_q     <= ACT_W'(ACT_TIMEOUT);
            act_led_q <= (ACT_TIMEOUT != 32'sd0);
        end else if (ce && (act_q != '0)) begin
            act_q     <= act_q - ACT_W'(1'b1);
            act_led_q <= (act_q != ACT_W'(1'b1));
        end else begin
            act_q     <= act_q;
            act_led_q <= act_led_q;
        end
    end

    assign activity_o = act_led_q;
`else
    // Without the LED the timeout is only referenced, never built.
    assign activity_o = 1'b0 & (ACT_TIMEOUT != 32'sd0);
`endif

endmodule

// File: tb/tb_tape_in_conditioner.sv
// Scoreboard bench for tape_in_conditioner (FILT_LEN=4, HOLDOFF=8, ACT_TIMEOUT=100).
module tb_tape_in_conditioner;

    localparam int FILT_LEN    = 4;
    localparam int HOLDOFF     = 8;
    localparam int ACT_TIMEOUT = 100;
    // One strobe goes to the synchroniser, then FILT_LEN strobes fill the window.
    localparam int ACCEPT_LAG  = FILT_LEN + 1;
`ifdef TAPE_ACTIVITY_LED_EN
    localparam int EXP_ACT_TICKS = ACT_TIMEOUT;
`else
    localparam int EXP_ACT_TICKS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        tape_raw;
    logic        invert;
    logic        tape_o;
    logic        edge_o;
    logic [15:0] period_o;
    logic        period_valid_o;
    logic        activity_o;

    int n_tests      = 0;
    int n_fail       = 0;
    int ce_n         = 0;
    int last_edge_ce = 0;
    bit armed        = 1'b0;
    int exp_edges    = 0;
    int edges_seen   = 0;
    int act_hi       = 0;
    int e0           = 0;
    logic [15:0] exp_period_q[$];

    always #5 clk = ~clk;

    tape_in_conditioner #(
        .FILT_LEN    (FILT_LEN),
        .HOLDOFF     (HOLDOFF),
        .ACT_TIMEOUT (ACT_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ce             (ce),
        .tape_raw       (tape_raw),
        .invert         (invert),
        .tape_o         (tape_o),
        .edge_o         (edge_o),
        .period_o       (period_o),
        .period_valid_o (period_valid_o),
        .activity_o     (activity_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tape"},     32'(tape_o),         32'd0);
        check_eq({tag, "_edge"},     32'(edge_o),         32'd0);
        check_eq({tag, "_period"},   32'(period_o),       32'd0);
        check_eq({tag, "_pvalid"},   32'(period_valid_o), 32'd0);
        check_eq({tag, "_activity"}, 32'(activity_o),     32'd0);
    endtask

    // One strobe every second clock: ce low for one clk, high for the next.
    task automatic tick(input int n);
        repeat (n) begin
            ce = 1'b0;
            @(negedge clk);
            ce = 1'b1;
            @(negedge clk);
            ce_n++;
        end
        ce = 1'b0;
    endtask

    task automatic fast_ce(input int n);
        ce = 1'b1;
        repeat (n) @(negedge clk);
        ce = 1'b0;
        ce_n += n;
    endtask

    // Model of an accepted rising edge caused by a level change driven now.
    task automatic expect_rise();
        int acc;
        int diff;
        acc  = ce_n + ACCEPT_LAG;
        diff = acc - last_edge_ce;
        if (armed) begin
            exp_period_q.push_back((diff >= 65535) ? 16'hFFFF : 16'(diff));
        end
        last_edge_ce = acc;
        armed        = 1'b1;
        exp_edges++;
    endtask

    // Output monitor: counts edges and scores every published period.
    always @(posedge clk) begin
        #1;
        if (edge_o) edges_seen++;
        if (period_valid_o) begin
            check_eq("pv_with_edge", 32'(edge_o), 32'd1);
            check_eq("pv_expected", 32'(exp_period_q.size() != 0), 32'd1);
            if (exp_period_q.size() != 0) begin
                check_eq("period", 32'(period_o), 32'(exp_period_q.pop_front()));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        ce       = 1'b0;
        tape_raw = 1'b0;
        invert   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset0");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset0");

        // First rising edge: latency, single pulse, no period.
        expect_rise();
        tape_raw = 1'b1;
        tick(FILT_LEN);
        check_eq("lat_early_tape", 32'(tape_o), 32'd0);
        tick(1);
        check_eq("lat_tape", 32'(tape_o), 32'd1);
        check_eq("lat_edge", 32'(edge_o), 32'd1);
        check_eq("first_pv", 32'(period_valid_o), 32'd0);
        act_hi = activity_o ? 1 : 0;

        // Short dip inside hold-off; activity window measured meanwhile.
        for (int i = 1; i <= 120; i++) begin
            if (i == 2) tape_raw = 1'b0;
            else if (i == 4) tape_raw = 1'b1;
            tick(1);
            check_eq("dip_tape", 32'(tape_o), 32'd1);
            if (activity_o) act_hi++;
        end
        check_eq("act_ticks", 32'(act_hi), 32'(EXP_ACT_TICKS));

        tape_raw = 1'b0;
        tick(20);
        check_eq("fall_tape", 32'(tape_o), 32'd0);

        // 3-strobe glitch on a low line.
        e0 = edges_seen;
        tape_raw = 1'b1;
        tick(3);
        tape_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("glitch_tape", 32'(tape_o), 32'd0);
        end
        check_eq("glitch_edges", 32'(edges_seen), 32'(e0));

        // Square wave, 40 strobes per period.
        for (int p = 0; p < 5; p++) begin
            expect_rise();
            tape_raw = 1'b1;
            tick(20);
            check_eq("sq_high", 32'(tape_o), 32'd1);
            tape_raw = 1'b0;
            tick(20);
            check_eq("sq_low", 32'(tape_o), 32'd0);
        end

        // Long quiet high level saturates the period timer.
        expect_rise();
        tape_raw = 1'b1;
        tick(20);
        fast_ce(70000);
        tick(2);
        tape_raw = 1'b0;
        tick(20);
        expect_rise();
        tape_raw = 1'b1;
        tick(20);
        check_eq("sat_period", 32'(period_o), 32'h0000FFFF);

        // Reset while in HOLD_HIGH with a strobe in the same clk.
        tape_raw = 1'b0;
        tick(20);
        expect_rise();
        tape_raw = 1'b1;
        tick(ACCEPT_LAG);
        check_eq("pre_rst_edge", 32'(edge_o), 32'd1);
        tick(2);
        reset    = 1'b1;
        ce       = 1'b1;
        tape_raw = 1'b0;
        armed    = 1'b0;
        @(negedge clk);
        check_all_zero("in_reset1");
        reset = 1'b0;
        ce    = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset1");
        tick(20);
        expect_rise();
        tape_raw = 1'b1;
        tick(25);
        check_eq("unarmed_tape", 32'(tape_o), 32'd1);
        check_eq("unarmed_period", 32'(period_o), 32'd0);
        tape_raw = 1'b0;
        tick(20);
        // Rising edge made by flipping invert with the line held low.
        expect_rise();
        invert = 1'b1;
        tick(25);
        check_eq("inv_tape", 32'(tape_o), 32'd1);
        tick(10);

        check_eq("sb_empty", 32'(exp_period_q.size()), 32'd0);
        check_eq("edge_count", 32'(edges_seen), 32'(exp_edges));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
